// File: rtl/mem_responder.sv
// mem_responder: single-outstanding data-memory responder.
// Accepts one load/store over valid/ready, waits LATENCY extra cycles,
// commits a byte-enabled write or a word read, then strobes a one-cycle
// response. While a request is in flight it asks the pipeline to stall.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall_o,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Counter must be able to hold LATENCY; keep at least one bit for LATENCY = 0.
  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Request captured at the accept edge; inputs are ignored afterwards.
  logic                    write_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              be_q;

  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    commit;
  logic                    addr_err;
  logic [ADDR_WIDTH-1:0]   word_idx;

  assign accept   = (state_q == IDLE) && req_valid;
  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  // Misaligned, or any address bit above the array is set.
  assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);

  // Next-state and commit decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY);
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Response data/error, updated only at commit and held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= addr_err;
      rdata_q <= (addr_err || write_q) ? '0 : mem[word_idx];
    end
  end

  // Byte-enabled array write at commit.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; clearing it would need a port per word and
    // its contents must survive a reset anyway.
    if (commit && write_q && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != IDLE);
  // Gated by rst so the freeze request is low throughout reset.
  assign stall_o    = rst && (accept || (state_q == WAIT));

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table of transactions with a
// response scoreboard, plus sequences for held requests, reset in WAIT and
// a LATENCY = 0 instance.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall_o;
  logic        busy;

  // LATENCY = 0 instance signals
  logic        req_valid0 = 1'b0;
  logic        req_ready0;
  logic        req_write0 = 1'b0;
  logic [31:0] req_addr0 = '0;
  logic [31:0] req_wdata0 = '0;
  logic [3:0]  req_be0 = '0;
  logic        resp_valid0;
  logic [31:0] resp_rdata0;
  logic        resp_err0;
  logic        stall0;
  logic        busy0;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_count = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall_o(stall_o), .busy(busy)
  );

  mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .stall_o(stall0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: pop and compare on every response strobe of the main DUT.
  always @(negedge clk) begin
    if (resp_valid) begin
      resp_count++;
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rdata", resp_rdata, e.rdata);
        check("sb_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // One transaction on the main DUT, presented in cycle 0 (just after an edge).
  task automatic do_txn(input vec_t v, input int idx);
    exp_t e;
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    for (int cyc = 0; cyc <= LAT + 2; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check($sformatf("v%0d_ready_c0", idx), 32'(req_ready), 32'd1);
      check($sformatf("v%0d_stall_c%0d", idx, cyc), 32'(stall_o), 32'(cyc <= LAT + 1));
      check($sformatf("v%0d_rvalid_c%0d", idx, cyc), 32'(resp_valid), 32'(cyc == LAT + 2));
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        // Scramble inputs after accept; they must have no effect.
        req_valid = 1'b0;
        req_wdata = 32'h0BAD_0BAD;
        req_addr  = 32'h0000_0004;
        req_be    = 4'b1111;
        req_write = ~v.write;
      end
    end
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0030, 32'h0000_0000, 4'b1111, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b1111, 32'h11BB_33DD, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0022, 32'h0000_0000, 4'b1111, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h11BB_33DD, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0011, 32'h5555_5555, 4'b1111, 32'h0, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'b1111, 32'h0, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'b1111, 32'h1234_5678, 1'b0};

    // Reset state, with req_valid high to show stall_o is held low.
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven transactions.
    for (int i = 0; i < 16; i++) begin
      do_txn(vecs[i], i);
    end

    // Held request: two loads back to back with req_valid never dropped.
    begin
      int base;
      exp_t e;
      base = resp_count;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0010;
      req_be    = 4'b1111;
      e.rdata = 32'hDEAD_BEEF;
      e.err   = 1'b0;
      sb.push_back(e);
      sb.push_back(e);
      for (int cyc = 0; cyc <= 9; cyc++) begin
        @(negedge clk);
        check($sformatf("held_ready_c%0d", cyc), 32'(req_ready), 32'(cyc == 0 || cyc == 5));
        check($sformatf("held_rvalid_c%0d", cyc), 32'(resp_valid), 32'(cyc == 4 || cyc == 9));
        @(posedge clk);
        #1;
        if (cyc == 8) req_valid = 1'b0;
      end
      check("held_resp_count", 32'(resp_count - base), 32'd2);
    end

    // Reset while a store to 0x30 is waiting: the store must be dropped.
    begin
      int base;
      base = resp_count;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0030;
      req_wdata = 32'h0000_0005;
      req_be    = 4'b1111;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = 1'b1;
      @(negedge clk);
      check("wrst_resp_valid", 32'(resp_valid), 32'd0);
      check("wrst_rdata", resp_rdata, 32'd0);
      check("wrst_err", 32'(resp_err), 32'd0);
      check("wrst_busy", 32'(busy), 32'd0);
      check("wrst_stall", 32'(stall_o), 32'd0);
      repeat (3) @(posedge clk);
      req_valid = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      check("wrst_no_resp", 32'(resp_count - base), 32'd0);
      @(posedge clk);
      #1;
      do_txn('{1'b0, 32'h0000_0030, 32'h0, 4'b1111, 32'h0000_0000, 1'b0}, 100);
      // A store that committed before the reset must survive it.
      do_txn('{1'b0, 32'h0000_0010, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b0}, 101);
    end

    // LATENCY = 0 instance: store, then load, checking timing of the load.
    req_valid0 = 1'b1;
    req_write0 = 1'b1;
    req_addr0  = 32'h0000_0040;
    req_wdata0 = 32'h0000_A5A5;
    req_be0    = 4'b1111;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid0 = 1'b1;
    req_write0 = 1'b0;
    for (int cyc = 0; cyc <= 3; cyc++) begin
      @(negedge clk);
      check($sformatf("l0_stall_c%0d", cyc), 32'(stall0), 32'(cyc <= 1));
      check($sformatf("l0_busy_c%0d", cyc), 32'(busy0), 32'(cyc == 1 || cyc == 2));
      check($sformatf("l0_rvalid_c%0d", cyc), 32'(resp_valid0), 32'(cyc == 2));
      if (cyc == 2) begin
        check("l0_rdata", resp_rdata0, 32'h0000_A5A5);
        check("l0_err", 32'(resp_err0), 32'd0);
      end
      @(posedge clk);
      #1;
      if (cyc == 0) req_valid0 = 1'b0;
    end

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the pipeline's data-memory interface. It accepts one load/store request at a time from the memory stage over a valid/ready handshake. It inserts a programmable number of wait states, then performs a byte-enabled write or a word read on an internal word array and returns a one-cycle response. While a request is outstanding it drives a stall to the hazard logic, so the pipeline freezes until the response arrives.

Parameters:
ADDR_WIDTH, 10, word-index width; array depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; fixed at 32 (byte enables are 4 bits)
LATENCY, 2, extra wait cycles before the access commits (0 allowed)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit i covers wdata[8i+7:8i]
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  load data (0 for stores and errors)
resp_err  output  1  misaligned or out-of-range request, qualified by resp_valid
stall_o  output  1  freeze request to the pipeline
busy  output  1  state != IDLE

Behaviour:
- Reset is asynchronous when rst = 0. Reset values:
  - state = IDLE, counter = 0
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0
  - stall_o = 0 for as long as rst = 0
  - The memory array is not cleared.
- FSM states:
  - IDLE: req_ready = 1. If req_valid = 1 on a clock edge, latch write, addr, wdata and be; load counter = LATENCY; go to WAIT.
  - WAIT: if counter != 0, decrement the counter and stay. If counter == 0, commit the access on this edge and go to RESP.
  - RESP: resp_valid = 1 for exactly this cycle; next state is IDLE unconditionally.
- Timing: with the request presented in cycle 0, the responder is in WAIT for cycles 1..LATENCY+1 and in RESP (resp_valid = 1) in cycle LATENCY+2.
- Throughput: the next request can be accepted at the earliest in cycle LATENCY+3. req_ready = 0 in WAIT and RESP, so a req_valid held high during RESP is not re-accepted until IDLE.
- Error check, evaluated on the latched address at commit:
  - err = (addr[1:0] != 0) OR (addr[31:ADDR_WIDTH+2] != 0).
  - On error: no array write, resp_rdata = 0, resp_err = 1.
- Store commit: for each i with be[i] = 1, mem[addr[ADDR_WIDTH+1:2]] byte i takes wdata byte i. Other bytes are unchanged. resp_rdata = 0.
  - A store with be = 0000 is legal: no change, resp_err = 0.
- Load commit: resp_rdata = the full 32-bit word. be is ignored for loads.
- resp_rdata and resp_err are registered and held until the next commit or reset. They are only meaningful while resp_valid = 1.
- stall_o = (state == IDLE & req_valid) | (state == WAIT). It is low in RESP, so the stage advances in the same cycle the data is valid.
- Reset mid-operation: a reset asserted in WAIT before the commit edge drops the request with no array write and no resp_valid. A store that has already committed is kept.
- Inputs are only sampled at the accept edge; changes to them during WAIT have no effect.

Test Plan:
- Basic store/load (LATENCY = 2): store addr 0x10, wdata 0xDEADBEEF, be 1111, then load 0x10 -> resp_valid in cycle 4 of each transaction, load resp_rdata = 0xDEADBEEF, resp_err = 0, stall_o high in cycles 0–3.
- Partial store: word 0x20 = 0x11223344, then store wdata 0xAABBCCDD with be 0101, then load 0x20 -> 0x11BB33DD.
- Errors:
  - Load 0x22 (misaligned) -> resp_err = 1, resp_rdata = 0.
  - Store to 0x1000 (out of range at ADDR_WIDTH = 10) -> resp_err = 1; a following load of 0x0 shows its prior value unchanged.
- Held request: req_valid kept high through RESP -> exactly one response per transaction, with the second accept in cycle 5.
- Reset in WAIT: store 0x30 = 0x5, assert rst = 0 in cycle 2 -> no resp_valid, all outputs 0. A following load of 0x30 returns the prior value 0x0 that was stored before the test.
- LATENCY = 0 build: load issued in cycle 0 -> WAIT in cycle 1, resp_valid in cycle 2, stall_o high in cycles 0–1.
